// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe; o_overflow exists only when
// CLA_OVERFLOW_EN is defined.
interface cla_adder_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] i_add1;
    logic [WIDTH-1:0] i_add2;
    logic             i_cin;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH:0]   o_result;
    logic             o_valid;
    logic             i_ready;
`ifdef CLA_OVERFLOW_EN
    logic             o_overflow;
`endif

    // Adder side
    modport slave (
        input  i_add1, i_add2, i_cin, i_valid, i_ready,
        output o_ready, o_result, o_valid
`ifdef CLA_OVERFLOW_EN
        , output o_overflow
`endif
    );

    // Issue/consumer side
    modport master (
        output i_add1, i_add2, i_cin, i_valid, i_ready,
        input  o_ready, o_result, o_valid
`ifdef CLA_OVERFLOW_EN
        , input o_overflow
`endif
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder, one BLOCK-bit group resolved per stage, valid/ready both sides.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output.
module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    cla_adder_pipe_if.slave        bus
);
    localparam int unsigned NGRP = WIDTH / BLOCK;

    if ((BLOCK == 0) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_bad_param
        $error("cla_adder_pipe: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Group lookahead: returns {carry_out, sum}
    function automatic logic [BLOCK:0] cla_grp(input logic [BLOCK-1:0] a,
                                               input logic [BLOCK-1:0] b,
                                               input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(BLOCK); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic [NGRP-1:0] v_all;
    logic [NGRP-1:0] load;

    // A stage may load unless it and every stage downstream of it is full and the sink stalls
    for (genvar k = 0; k < NGRP; k++) begin : g_load
        assign load[k] = bus.i_ready | ~(&v_all[NGRP-1:k]);
    end

    assign bus.o_ready = load[0];

    // acc carries finished sum groups on top and still-pending A groups rotated to the bottom
    for (genvar k = 0; k < NGRP; k++) begin : g_stg
        localparam int unsigned REM = WIDTH - BLOCK * k;

        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] acc_nx;
        logic [WIDTH-1:0] acc_q;
        logic [REM-1:0]   b_in;
        logic             c_in;
        logic             v_in;
        logic             v_q;
        logic             c_q;
        logic [BLOCK-1:0] s_grp;
        logic             c_out;
        logic             en;

        if (k == 0) begin : g_src
            assign acc_in = bus.i_add1;
            assign b_in   = bus.i_add2;
            assign c_in   = bus.i_cin;
            assign v_in   = bus.i_valid;
        end else begin : g_src
            assign acc_in = g_stg[k-1].acc_q;
            assign b_in   = g_stg[k-1].g_b.b_q;
            assign c_in   = g_stg[k-1].c_q;
            assign v_in   = g_stg[k-1].v_q;
        end

        assign {c_out, s_grp} = cla_grp(acc_in[BLOCK-1:0], b_in[BLOCK-1:0], c_in);
        assign en             = load[k] & v_in;

        if (WIDTH > BLOCK) begin : g_rot
            assign acc_nx = {s_grp, acc_in[WIDTH-1:BLOCK]};
        end else begin : g_rot
            assign acc_nx = s_grp;
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else begin
                if (load[k]) v_q <= v_in;
                if (en) begin
                    c_q   <= c_out;
                    acc_q <= acc_nx;
                end
            end
        end

        assign v_all[k] = v_q;

        if (k < NGRP - 1) begin : g_b
            logic [REM-BLOCK-1:0] b_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)   b_q <= '0;
                else if (en) b_q <= b_in[REM-1:BLOCK];
            end
        end else begin : g_out
            assign bus.o_valid  = v_q;
            assign bus.o_result = {c_q, acc_q};
`ifdef CLA_OVERFLOW_EN
            // Same-sign operands giving an opposite-sign sum == carry into MSB ^ carry out
            logic ovf_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)   ovf_q <= 1'b0;
                else if (en) ovf_q <= (acc_in[BLOCK-1] == b_in[BLOCK-1]) &&
                                      (s_grp[BLOCK-1] != acc_in[BLOCK-1]);
            end
            assign bus.o_overflow = ovf_q;
`endif
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed vector table, handshake sequences and
// randomized traffic against an arithmetic reference model.
module tb_cla_adder_pipe;
    localparam int unsigned W    = 16;
    localparam int unsigned B    = 4;
    localparam int unsigned NGRP = W / B;
    localparam int unsigned NOPS = 3000;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   res;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    cla_adder_pipe_if #(.WIDTH(W)) bus ();

    cla_adder_pipe #(.WIDTH(W), .BLOCK(B)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        longint unsigned s;
        s = longint'(a) + longint'(b) + longint'(cin);
        return (W+1)'(s);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        return (s > (longint'(1) <<< (W-1)) - 1) || (s < -(longint'(1) <<< (W-1)));
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        bus.i_valid = v;
        bus.i_add1  = a;
        bus.i_add2  = b;
        bus.i_cin   = cin;
    endtask

    vec_t vecs[13];
    exp_t sb[$];

    initial begin
        int   lat;
        exp_t e;
        logic [W:0] held_res;
        logic hold;
        int   accepted;
        int   cyc;
        logic [W-1:0] ra, rb;
        logic rc;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0};
        vecs[6]  = '{16'h0F0F, 16'hF0F0, 1'b1, 17'h10000, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1};
        vecs[8]  = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1};
        vecs[9]  = '{16'hABCD, 16'h1111, 1'b1, 17'h0BCDF, 1'b0};
        vecs[10] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0};
        vecs[11] = '{16'h4000, 16'h4000, 1'b0, 17'h08000, 1'b1};
        vecs[12] = '{16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 1'b1};

        rst = 1'b1;
        bus.i_ready = 1'b1;
        drive(1'b1, 16'h5A5A, 16'hA5A5, 1'b1);
        tick();
        tick();
        chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_o_result", 64'(bus.o_result), 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #1;
        chk("reset_o_ready", 64'(bus.o_ready), 64'd1);
        tick();
        chk("reset_no_output", 64'(bus.o_valid), 64'd0);

        // Directed vectors, one at a time, with latency measurement
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            tick();
            drive(1'b0, '0, '0, 1'b0);
            lat = 1;
            while (!bus.o_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NGRP));
            chk($sformatf("vec%0d_result", i), 64'(bus.o_result), 64'(vecs[i].res));
`ifdef CLA_OVERFLOW_EN
            chk($sformatf("vec%0d_overflow", i), 64'(bus.o_overflow), 64'(vecs[i].ovf));
`endif
            tick();
            chk($sformatf("vec%0d_valid_drop", i), 64'(bus.o_valid), 64'd0);
        end

        // Back-to-back stream, consumer always ready
        for (int c = 0; c < int'(NGRP) + 10; c++) begin
            if (c < 8) drive(1'b1, W'(c), W'(2 * c), 1'(c & 1));
            else       drive(1'b0, '0, '0, 1'b0);
            #1;
            if (c < 8) chk($sformatf("b2b_ready%0d", c), 64'(bus.o_ready), 64'd1);
            chk($sformatf("b2b_valid%0d", c), 64'(bus.o_valid),
                64'((c >= int'(NGRP)) && (c < int'(NGRP) + 8)));
            if (bus.o_valid && c >= int'(NGRP))
                chk($sformatf("b2b_result%0d", c), 64'(bus.o_result),
                    64'(3 * (c - int'(NGRP)) + ((c - int'(NGRP)) & 1)));
            tick();
        end

        // Fill with consumer stalled, hold 5 cycles, then drain
        bus.i_ready = 1'b0;
        for (int c = 0; c < int'(NGRP); c++) begin
            drive(1'b1, W'(c * 16'h1111), 16'h0F0F, 1'(c & 1));
            #1;
            chk($sformatf("fill_ready%0d", c), 64'(bus.o_ready), 64'd1);
            tick();
        end
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall_ready%0d", c), 64'(bus.o_ready), 64'd0);
            chk($sformatf("stall_valid%0d", c), 64'(bus.o_valid), 64'd1);
            chk($sformatf("stall_result%0d", c), 64'(bus.o_result), 64'(ref_sum(16'h0000, 16'h0F0F, 1'b0)));
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        bus.i_ready = 1'b1;
        for (int c = 0; c < int'(NGRP); c++) begin
            #1;
            chk($sformatf("drain_ready%0d", c), 64'(bus.o_ready), 64'd1);
            chk($sformatf("drain_valid%0d", c), 64'(bus.o_valid), 64'd1);
            chk($sformatf("drain_result%0d", c), 64'(bus.o_result),
                64'(ref_sum(W'(c * 16'h1111), 16'h0F0F, 1'(c & 1))));
            tick();
        end
        chk("drain_empty", 64'(bus.o_valid), 64'd0);

        // Reset with three transactions in flight
        bus.i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 16'hFFF0 + W'(c), 16'h0010, 1'b0);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        tick();
        chk("midrst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_o_result", 64'(bus.o_result), 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        bus.i_ready = 1'b1;
        #1;
        chk("midrst_o_ready", 64'(bus.o_ready), 64'd1);
        for (int c = 0; c < int'(NGRP) + 2; c++) begin
            tick();
            chk($sformatf("midrst_stale%0d", c), 64'(bus.o_valid), 64'd0);
        end

        // Randomized traffic against the scoreboard
        accepted = 0;
        hold     = 1'b0;
        held_res = '0;
        cyc      = 0;
        while ((accepted < int'(NOPS) || sb.size() != 0) && cyc < 40000) begin
            if (hold) begin
                chk("rand_hold_valid", 64'(bus.o_valid), 64'd1);
                chk("rand_hold_result", 64'(bus.o_result), 64'(held_res));
            end
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (($urandom_range(0, 7) == 0)) ra = '1;
            drive((accepted < int'(NOPS)) && ($urandom_range(0, 3) != 0), ra, rb, rc);
            bus.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_unexpected: got output 0x%0h, expected none", bus.o_result);
                end else begin
                    e = sb.pop_front();
                    chk("rand_result", 64'(bus.o_result), 64'(e.res));
`ifdef CLA_OVERFLOW_EN
                    chk("rand_overflow", 64'(bus.o_overflow), 64'(e.ovf));
`endif
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                e.res = ref_sum(ra, rb, rc);
                e.ovf = ref_ovf(ra, rb, rc);
                sb.push_back(e);
                accepted++;
            end
            hold     = bus.o_valid && !bus.i_ready;
            held_res = bus.o_result;
            tick();
            cyc++;
        end
        chk("rand_all_accepted", 64'(accepted), 64'(NOPS));
        chk("rand_sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
